// File: rtl/mcpu_boot_ctrl_pkg.sv
// mcpu_boot_ctrl_pkg: shared CPU memory sizes and boot FSM state encoding
package mcpu_boot_ctrl_pkg;
  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 8;
  localparam int RAM_SIZE = 256;
  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [ADDR_SIZE:0] cnt_t;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } state_t;
endpackage

// File: rtl/mcpu_boot_ctrl_if.sv
// mcpu_boot_ctrl_if: loader stream and RAM write port of the boot controller
interface mcpu_boot_ctrl_if;
  import mcpu_boot_ctrl_pkg::*;
  logic in_valid;
  word_t in_data;
  logic in_last;
  logic in_ready;
  logic ram_we;
  addr_t ram_addr;
  word_t ram_wdata;
  modport slave(input in_valid, in_data, in_last, output in_ready, ram_we, ram_addr, ram_wdata);
  modport master(output in_valid, in_data, in_last, input in_ready, ram_we, ram_addr, ram_wdata);
endinterface

// File: rtl/mcpu_boot_ctrl.sv
// mcpu_boot_ctrl: clears the CPU RAM, loads a streamed program into it, then releases the CPU reset
module mcpu_boot_ctrl
  import mcpu_boot_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  mcpu_boot_ctrl_if.slave bus,
  output logic           cpu_reset,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output cnt_t           load_count
);
  state_t state_q, state_d;
  logic ram_we_q, ram_we_d, overflow_q, overflow_d, cpu_reset_q, busy_q, done_q, full;
  addr_t ram_addr_q, ram_addr_d;
  word_t ram_wdata_q, ram_wdata_d;
  cnt_t load_count_q, load_count_d;
  assign full = load_count_q == cnt_t'(RAM_SIZE-1);
  assign bus.in_ready = state_q == LOAD;
  assign bus.ram_we = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy = busy_q;
  assign done = done_q;
  assign overflow = overflow_q;
  assign load_count = load_count_q;
  always_comb begin
    state_d = state_q;
    ram_we_d = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    load_count_d = load_count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, RUN: if (start) begin
        state_d = CLEAR;
        ram_we_d = 1'b1;
        ram_addr_d = '0;
        ram_wdata_d = '0;
        load_count_d = '0;
        overflow_d = 1'b0;
      end
      CLEAR: begin
        ram_we_d = ram_addr_q != addr_t'(RAM_SIZE-1);
        ram_addr_d = ram_addr_q + 1'b1;
        state_d = ram_we_d ? CLEAR : LOAD;
      end
      LOAD: if (bus.in_valid) begin
        ram_we_d = 1'b1;
        ram_addr_d = load_count_q[ADDR_SIZE-1:0];
        ram_wdata_d = bus.in_data;
        load_count_d = load_count_q + 1'b1;
        overflow_d = full && !bus.in_last;
        state_d = (bus.in_last || full) ? RELEASE : LOAD;
      end
      RELEASE: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      load_count_q <= '0;
      overflow_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      load_count_q <= load_count_d;
      overflow_q <= overflow_d;
      cpu_reset_q <= state_d != RUN;
      busy_q <= state_d inside {CLEAR, LOAD, RELEASE};
      done_q <= state_d == RUN;
    end
  end
endmodule

// File: tb/tb_mcpu_boot_ctrl.sv
// tb_mcpu_boot_ctrl: randomized directed bench checking the boot controller against a stream-level model
module tb_mcpu_boot_ctrl;
  import mcpu_boot_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, busy, done, overflow;
  cnt_t load_count;
  word_t ram_mem [RAM_SIZE];
  word_t words [RAM_SIZE+1];
  int n_chk = 0;
  int n_fail = 0;
  int sent;
  mcpu_boot_ctrl_if bus();
  mcpu_boot_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .load_count(load_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.ram_we === 1'b1) ram_mem[bus.ram_addr] = bus.ram_wdata;
  endtask
  task automatic chk_ram(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < RAM_SIZE; i++)
      if (ram_mem[i] !== (i < n ? words[i] : word_t'(0))) bad++;
    chk(tag, bad, 0);
  endtask
  task automatic do_clear(input bit poke);
    int bad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_first_we", bus.ram_we, 1);
    for (int k = 0; k < RAM_SIZE; k++) begin
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== addr_t'(k) || bus.ram_wdata !== word_t'(0)) bad++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) bad++;
      start = poke && k == 100;
      bus.in_valid = 1'($urandom);
      bus.in_data = word_t'($urandom);
      tick();
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_seq", bad, 0);
    chk("load_in_ready", bus.in_ready, 1);
    chk("load_entry_we", bus.ram_we, 0);
    chk("load_entry_count", load_count, 0);
    chk("load_entry_ovf", overflow, 0);
  endtask
  task automatic run_load(input int n, input bit with_last, input bit gaps, input bit poke, input int abort, output int acc);
    int bad = 0;
    int guard = 0;
    bit exp_rdy = 1'b1;
    bit fin = 1'b0;
    bit hs, lst;
    acc = 0;
    while (!fin && guard < 4000) begin
      guard++;
      bus.in_valid = (acc < n) && (!gaps || $urandom_range(1, 0) == 1);
      bus.in_data = acc < n ? words[acc] : word_t'($urandom);
      bus.in_last = with_last && acc == n - 1;
      start = poke && acc == 3;
      lst = bus.in_last;
      if (bus.in_ready !== exp_rdy) bad++;
      hs = bus.in_valid && exp_rdy;
      tick();
      if (bus.ram_we !== hs) bad++;
      if (hs) begin
        if (bus.ram_addr !== addr_t'(acc) || bus.ram_wdata !== words[acc]) bad++;
        acc++;
        if (load_count !== cnt_t'(acc)) bad++;
        if (lst || acc == RAM_SIZE) begin
          exp_rdy = 1'b0;
          fin = 1'b1;
        end
        if (acc == abort) break;
      end
    end
    start = 1'b0;
    chk("load_seq", bad, 0);
    chk("load_progress", fin || acc == abort, 1);
    if (fin) begin
      chk("release_in_ready", bus.in_ready, 0);
      chk("release_cpu_reset", cpu_reset, 1);
      chk("release_busy", busy, 1);
      bus.in_valid = acc < n;
      bus.in_data = acc < n ? words[acc] : '0;
      bus.in_last = 1'b0;
      tick();
      chk("run_we", bus.ram_we, 0);
      chk("run_cpu_reset", cpu_reset, 0);
      chk("run_done", done, 1);
      chk("run_busy", busy, 0);
      chk("run_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    for (int i = 0; i < RAM_SIZE; i++) ram_mem[i] = word_t'($urandom);
    repeat (3) tick();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", load_count, 0);
    reset = 1'b0;
    tick();
    chk("idle_cpu_reset", cpu_reset, 1);
    chk("idle_in_ready", bus.in_ready, 0);
    do_clear(1'b0);
    for (int i = 0; i < 11; i++) words[i] = word_t'(16'h2201 + 16'h0101 * i);
    run_load(11, 1'b1, 1'b0, 1'b0, -1, sent);
    chk("t2_count", load_count, 11);
    chk("t2_overflow", overflow, 0);
    chk_ram("t2_ram", 11);
    do_clear(1'b1);
    run_load(11, 1'b1, 1'b1, 1'b1, -1, sent);
    chk("t3_count", load_count, 11);
    chk("t3_overflow", overflow, 0);
    chk_ram("t3_ram", 11);
    for (int i = 0; i <= RAM_SIZE; i++) words[i] = word_t'($urandom);
    do_clear(1'b0);
    run_load(RAM_SIZE + 1, 1'b0, 1'b0, 1'b0, -1, sent);
    chk("t4_sent", sent, RAM_SIZE);
    chk("t4_count", load_count, RAM_SIZE);
    chk("t4_overflow", overflow, 1);
    chk_ram("t4_ram", RAM_SIZE);
    for (int i = 0; i <= RAM_SIZE; i++) words[i] = word_t'($urandom);
    do_clear(1'b0);
    run_load(RAM_SIZE, 1'b1, 1'b1, 1'b0, -1, sent);
    chk("full_last_count", load_count, RAM_SIZE);
    chk("full_last_overflow", overflow, 0);
    chk_ram("full_last_ram", RAM_SIZE);
    for (int i = 0; i <= RAM_SIZE; i++) words[i] = word_t'($urandom);
    do_clear(1'b0);
    run_load(20, 1'b1, 1'b0, 1'b0, 5, sent);
    chk("t5_partial", load_count, 5);
    reset = 1'b1;
    tick();
    chk("t5_cpu_reset", cpu_reset, 1);
    chk("t5_we", bus.ram_we, 0);
    chk("t5_count", load_count, 0);
    chk("t5_in_ready", bus.in_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i <= RAM_SIZE; i++) words[i] = word_t'($urandom);
    do_clear(1'b0);
    run_load(9, 1'b1, 1'b1, 1'b0, -1, sent);
    chk("t5_reload_count", load_count, 9);
    chk_ram("t5_reload_ram", 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
